quad_input_filter: RTL

- Front-end conditioner for the two quadrature encoders. Sits directly upstream of the encoder decoder/counter block, between the raw A/B pins and the decoder's phase inputs.
- Synchronises all four phase inputs and applies a per-channel, sample-based glitch filter.
- Flags illegal quadrature transitions, where both phases of one encoder change at once.
- Holds a settle state after reset so that power-up input levels are not reported as errors.

---
 rtl/quad_input_filter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/quad_input_filter.sv
// Input conditioner for two quadrature encoders: 2-flop synchronisers, per-channel
// sample-based glitch filters, a post-reset settle period, and sticky illegal-transition flags.
module quad_input_filter #(
    parameter int unsigned SAMPLE_DIV = 50,
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in1A,
    input  logic in1B,
    input  logic in2A,
    input  logic in2B,
    input  logic err_clr,
    output logic out1A,
    output logic out1B,
    output logic out2A,
    output logic out2B,
    output logic ready,
    output logic err1,
    output logic err2
);

    localparam int unsigned CntW        = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned SettleTicks = FILTER_LEN + 3;
    localparam int unsigned SetW        = $clog2(SettleTicks + 1);

    typedef enum logic {StSettle, StRun} state_e;

    // Channel order: bit 0 = 1A, 1 = 1B, 2 = 2A, 3 = 2B.
    logic [3:0]           pin;
    logic [3:0]           s1_q, s2_q;
    logic [3:0]           out_q, out_d;
    logic [3:0]           chg_q, chg_d;
    logic [3:0][CntW-1:0] cnt_q, cnt_d;
    logic                 tick;
    state_e               state_q, state_d;
    logic [SetW-1:0]      settle_q, settle_d;
    logic                 err_en;
    logic [1:0]           err_q, err_d;

    assign pin = {in2B, in2A, in1B, in1A};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pin;
            s2_q <= s1_q;
        end
    end

    if (SAMPLE_DIV == 1) begin : g_tick_every
        assign tick = 1'b1;
    end else begin : g_tick_div
        localparam int unsigned TickW = $clog2(SAMPLE_DIV);
        logic [TickW-1:0] tick_q;

        assign tick = (tick_q == TickW'(SAMPLE_DIV - 1));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tick_q <= '0;
            end else begin
                tick_q <= tick ? '0 : tick_q + 1'b1;
            end
        end
    end

    // A filtered output flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (s2_q[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
                    out_d[i] = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        chg_d = out_d ^ out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            cnt_q <= '0;
            chg_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StSettle;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            StSettle: begin
                if (tick) begin
                    settle_d = settle_q + 1'b1;
                    if (settle_q == SetW'(SettleTicks - 1)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: ;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        err_en = 1'b0;
        unique case (state_q)
            StSettle: ;
            StRun: begin
                ready  = 1'b1;
                err_en = 1'b1;
            end
        endcase
    end

    // A new set condition overrides a simultaneous clear.
    always_comb begin
        err_d = '0;
        for (int n = 0; n < 2; n++) begin
            err_d[n] = (err_en & chg_q[2*n] & chg_q[2*n+1]) | (err_q[n] & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign out1A = out_q[0];
    assign out1B = out_q[1];
    assign out2A = out_q[2];
    assign out2B = out_q[3];
    assign err1  = err_q[0];
    assign err2  = err_q[1];

endmodule
